vidout_sync_decoder: RTL and testbench
======================================

# vidout_sync_decoder

Receive-side counterpart of the PPU composite video generator. Takes the generator's output stream, already converted to one unsigned amplitude per CLK, and performs sync separation (hsync vs. broad vsync pulses), line-length measurement and lock detection. While locked, it also resamples the active line into pixel strobes with X/Y coordinates. Used in benches and the capture path to turn generated video back into a pixel stream for checking against the PPU's intended output.

## Interface
Parameters:
- SYNC_TH, 11'd64: sample strictly below this is "sync low"
- HSYNC_MIN, 50: minimum low length (CLK) accepted as hsync; shorter = glitch, ignored
- VSYNC_MIN, 400: low length ≥ this = vsync (broad pulse)
- LINE_NOM, 1364: nominal line length in CLK
- LINE_TOL, 8: allowed ± deviation from LINE_NOM for lock
- LINE_MAX, 1500: no sync for this many CLK -> lock lost
- ACTIVE_START, 200: CLK from HSYNC_DET to first pixel sample
- PIX_DIV, 4: CLK per pixel
- ACTIVE_PIX, 256: pixels per line

Ports:
- CLK  in  1  master clock, one sample per cycle
- RES  in  1  reset, asynchronous, active-high
- VIN  in  11  composite sample, unsigned amplitude, 0 = sync tip
- HSYNC_DET  out  1  one-CLK pulse per classified hsync
- VSYNC_DET  out  1  one-CLK pulse per classified broad pulse
- LOCKED  out  1  line timing within tolerance
- LINE_LEN  out  12  last measured hsync-to-hsync interval in CLK
- PIX_STB  out  1  pixel sample valid
- PIX_X  out  9  pixel index 0..ACTIVE_PIX-1
- PIX_Y  out  9  line index since last vsync
- PIX_LVL  out  11  sampled amplitude

## Operation
- VIN is registered (vin_q). Low = vin_q < SYNC_TH.
- Classifier FSM:
  - HIGH -> LOW on low; clear low counter (12 bit, saturating at 4095).
  - LOW counts each low cycle.
  - LOW -> HIGH on the first non-low vin_q. Classification on that transition: count < HSYNC_MIN: nothing; HSYNC_MIN ≤ count < VSYNC_MIN: HSYNC_DET; count ≥ VSYNC_MIN: VSYNC_DET. The two pulses never coincide.
- Line counter (12 bit, saturating) restarts to 1 on every HSYNC_DET or VSYNC_DET and increments otherwise.
- On HSYNC_DET:
  - LINE_LEN <= counter value, only if the previous classified sync was also hsync.
  - LOCKED <= 1 if that value is within [LINE_NOM-LINE_TOL, LINE_NOM+LINE_TOL]; else LOCKED <= 0.
- Lock loss: LOCKED <= 0 when the counter reaches LINE_MAX. VSYNC_DET does not change LOCKED.
- PIX_Y on HSYNC_DET:
  - vsync flag set: PIX_Y <= 0, clear flag.
  - Otherwise PIX_Y increments, saturating at 511.
  - The flag is set by VSYNC_DET. Several consecutive broad pulses leave the flag set.
- Pixel engine (IDLE/WAIT/ACTIVE):
  - Any HSYNC_DET while LOCKED=1 (evaluated with the pre-update value) enters WAIT.
  - ACTIVE emits ACTIVE_PIX strobes, then returns to IDLE.
  - A new HSYNC_DET or VSYNC_DET in any state aborts the current line. HSYNC_DET restarts WAIT; VSYNC_DET goes to IDLE.
  - LOCKED falling also goes to IDLE.

## Timing
- Reset values: all outputs 0; FSMs in HIGH / IDLE; counters 0; vsync flag 0.
- Latency: VIN rising above threshold at input in cycle n -> HSYNC_DET/VSYNC_DET high in cycle n+2 (input register plus classification register).
- With t0 = the HSYNC_DET cycle, PIX_STB is high at t0+ACTIVE_START+k·PIX_DIV for k = 0..ACTIVE_PIX-1.
  - PIX_X = k.
  - PIX_LVL = vin_q of that same cycle.
  - PIX_Y is stable for the whole line.
- Outputs are registered and change only on CLK rising edges, except that asynchronous RES clears them immediately, including mid-line and mid-pulse.

## Structure
- Package vidout_dec_pkg holds:
  - the parameter defaults and sample width (11);
  - counter widths (12 and 9);
  - the classifier and pixel FSM state enums.
- One sub-module, sync_pulse_classifier, contains the input register, low counter and HIGH/LOW FSM, and outputs HSYNC_DET/VSYNC_DET.
- Top level contains the line counter, lock logic, Y tracking and pixel engine.

## Test plan
- Reset: RES high mid-stream -> all outputs 0 in the same cycle. After release with VIN constant 500, no pulses and LOCKED=0.
- Glitch rejection: 49-CLK low pulse of VIN=0 -> no HSYNC_DET. 50-CLK pulse -> HSYNC_DET 2 cycles after VIN returns to 500.
- Lock: hsync lines of 1364 CLK -> LINE_LEN=1364 and LOCKED=1 after the second HSYNC_DET. One 1380-CLK line -> LOCKED=0 at that hsync. No sync for 1500 CLK -> LOCKED=0.
- Pixel capture: locked line with VIN=200+(c mod 256) -> 256 strobes.
  - First strobe 200 CLK after HSYNC_DET, spaced 4 CLK apart.
  - PIX_X runs 0..255; each PIX_LVL matches the registered VIN at its strobe.
- Vsync: three 500-CLK broad pulses -> three VSYNC_DET pulses; the next hsync gives PIX_Y=0, the following one gives 1.
- Abort: HSYNC_DET arrives after strobe 100 -> strobes stop and the sequence restarts at PIX_X=0, ACTIVE_START later.

Source files
------------

// File: rtl/vidout_dec_pkg.sv
// vidout_dec_pkg: shared widths, parameter defaults and FSM state types for the composite sync decoder.
package vidout_dec_pkg;
    localparam int SAMPLE_W = 11;
    localparam int CNT_W    = 12;
    localparam int Y_W      = 9;
    localparam logic [SAMPLE_W-1:0] SYNC_TH_DEF = 11'd64;
    localparam int HSYNC_MIN_DEF    = 50;
    localparam int VSYNC_MIN_DEF    = 400;
    localparam int LINE_NOM_DEF     = 1364;
    localparam int LINE_TOL_DEF     = 8;
    localparam int LINE_MAX_DEF     = 1500;
    localparam int ACTIVE_START_DEF = 200;
    localparam int PIX_DIV_DEF      = 4;
    localparam int ACTIVE_PIX_DEF   = 256;

    typedef enum logic {CLS_HIGH, CLS_LOW} cls_state_e;
    typedef enum logic [1:0] {PIX_IDLE, PIX_WAIT, PIX_ACTIVE} pix_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/sync_pulse_classifier.sv
// sync_pulse_classifier: registers the sample stream, measures each sync-low run and
// classifies it on its trailing edge as glitch, hsync or broad (vsync) pulse.
module sync_pulse_classifier
    import vidout_dec_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] SYNC_TH = SYNC_TH_DEF,
    parameter int HSYNC_MIN = HSYNC_MIN_DEF,
    parameter int VSYNC_MIN = VSYNC_MIN_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SAMPLE_W-1:0] vin_i,
    output logic                hsync_o,
    output logic                vsync_o
);
    localparam logic [CNT_W-1:0] HMIN = CNT_W'(HSYNC_MIN);
    localparam logic [CNT_W-1:0] VMIN = CNT_W'(VSYNC_MIN);

    logic [SAMPLE_W-1:0] vin_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    cls_state_e          state_q, state_d;
    logic                hs_q, hs_d, vs_q, vs_d, lo;

    assign lo      = vin_q < SYNC_TH;
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;

    // The entry cycle already counts as one low sample, so a run of N lows ends with count N.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hs_d    = 1'b0;
        vs_d    = 1'b0;
        if (state_q == CLS_HIGH) begin
            if (lo) begin
                state_d = CLS_LOW;
                cnt_d   = CNT_W'(1);
            end
        end else if (lo) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            state_d = CLS_HIGH;
            hs_d    = cnt_q >= HMIN && cnt_q < VMIN;
            vs_d    = cnt_q >= VMIN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vin_q   <= '0;
            cnt_q   <= '0;
            state_q <= CLS_HIGH;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            vin_q   <= vin_i;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end
endmodule

// File: rtl/vidout_sync_decoder.sv
// vidout_sync_decoder: sync separation, line-length lock detection and active-line
// resampling of the composite video stream into pixel strobes with X/Y coordinates.
module vidout_sync_decoder
    import vidout_dec_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] SYNC_TH = SYNC_TH_DEF,
    parameter int HSYNC_MIN    = HSYNC_MIN_DEF,
    parameter int VSYNC_MIN    = VSYNC_MIN_DEF,
    parameter int LINE_NOM     = LINE_NOM_DEF,
    parameter int LINE_TOL     = LINE_TOL_DEF,
    parameter int LINE_MAX     = LINE_MAX_DEF,
    parameter int ACTIVE_START = ACTIVE_START_DEF,
    parameter int PIX_DIV      = PIX_DIV_DEF,
    parameter int ACTIVE_PIX   = ACTIVE_PIX_DEF
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic [SAMPLE_W-1:0] VIN,
    output logic                HSYNC_DET,
    output logic                VSYNC_DET,
    output logic                LOCKED,
    output logic [CNT_W-1:0]    LINE_LEN,
    output logic                PIX_STB,
    output logic [Y_W-1:0]      PIX_X,
    output logic [Y_W-1:0]      PIX_Y,
    output logic [SAMPLE_W-1:0] PIX_LVL
);
    localparam logic [CNT_W-1:0] LEN_LO   = CNT_W'(LINE_NOM - LINE_TOL);
    localparam logic [CNT_W-1:0] LEN_HI   = CNT_W'(LINE_NOM + LINE_TOL);
    localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(LINE_MAX);
    localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(ACTIVE_START - 1);
    localparam logic [CNT_W-1:0] DIV_END  = CNT_W'(PIX_DIV - 1);
    localparam logic [Y_W-1:0]   PIX_LAST = Y_W'(ACTIVE_PIX - 1);

    logic                hs, vs, sync, fall;
    logic [CNT_W-1:0]    lc_q, lc_d, len_q, len_d, wcnt_q, wcnt_d, div_q, div_d;
    logic                lock_q, lock_d, prev_hs_q, prev_hs_d, vflag_q, vflag_d, stb_q, stb_d;
    logic [Y_W-1:0]      y_q, y_d, x_q, x_d, nxt_q, nxt_d;
    logic [SAMPLE_W-1:0] lvl_q, lvl_d;
    pix_state_e          pst_q, pst_d;

    sync_pulse_classifier #(
        .SYNC_TH  (SYNC_TH),
        .HSYNC_MIN(HSYNC_MIN),
        .VSYNC_MIN(VSYNC_MIN)
    ) u_cls (
        .clk_i  (CLK),
        .rst_i  (RES),
        .vin_i  (VIN),
        .hsync_o(hs),
        .vsync_o(vs)
    );

    assign sync      = hs | vs;
    assign fall      = lock_q & ~lock_d;
    assign HSYNC_DET = hs;
    assign VSYNC_DET = vs;
    assign LOCKED    = lock_q;
    assign LINE_LEN  = len_q;
    assign PIX_STB   = stb_q;
    assign PIX_X     = x_q;
    assign PIX_Y     = y_q;
    assign PIX_LVL   = lvl_q;

    // An interval that started at a broad pulse is not a line, so it never updates the lock.
    always_comb begin
        lc_d      = sync ? CNT_W'(1) : sat_inc(lc_q);
        len_d     = len_q;
        lock_d    = lock_q;
        prev_hs_d = prev_hs_q;
        vflag_d   = vflag_q;
        y_d       = y_q;
        if (hs) begin
            if (prev_hs_q) begin
                len_d  = lc_q;
                lock_d = lc_q >= LEN_LO && lc_q <= LEN_HI;
            end
            prev_hs_d = 1'b1;
            vflag_d   = 1'b0;
            y_d       = vflag_q ? '0 : (&y_q ? y_q : y_q + Y_W'(1));
        end else if (vs) begin
            prev_hs_d = 1'b0;
            vflag_d   = 1'b1;
        end else if (lc_d >= LEN_MAX) begin
            lock_d = 1'b0;
        end
    end

    // VIN is what the input register holds next cycle, i.e. the vin_q seen with the strobe.
    always_comb begin
        pst_d  = pst_q;
        wcnt_d = wcnt_q;
        div_d  = div_q;
        nxt_d  = nxt_q;
        stb_d  = 1'b0;
        x_d    = x_q;
        lvl_d  = lvl_q;
        if (hs) begin
            pst_d  = lock_q ? PIX_WAIT : PIX_IDLE;
            wcnt_d = CNT_W'(1);
        end else if (vs || fall) begin
            pst_d = PIX_IDLE;
        end else if (pst_q == PIX_WAIT) begin
            wcnt_d = wcnt_q + CNT_W'(1);
            if (wcnt_q == WAIT_END) begin
                pst_d = PIX_ACTIVE;
                div_d = '0;
                nxt_d = Y_W'(1);
                stb_d = 1'b1;
                x_d   = '0;
                lvl_d = VIN;
            end
        end else if (pst_q == PIX_ACTIVE) begin
            div_d = (div_q == DIV_END) ? '0 : div_q + CNT_W'(1);
            if (div_q == DIV_END) begin
                pst_d = (nxt_q == PIX_LAST) ? PIX_IDLE : PIX_ACTIVE;
                nxt_d = nxt_q + Y_W'(1);
                stb_d = 1'b1;
                x_d   = nxt_q;
                lvl_d = VIN;
            end
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            lc_q      <= '0;
            len_q     <= '0;
            lock_q    <= 1'b0;
            prev_hs_q <= 1'b0;
            vflag_q   <= 1'b0;
            y_q       <= '0;
            pst_q     <= PIX_IDLE;
            wcnt_q    <= '0;
            div_q     <= '0;
            nxt_q     <= '0;
            stb_q     <= 1'b0;
            x_q       <= '0;
            lvl_q     <= '0;
        end else begin
            lc_q      <= lc_d;
            len_q     <= len_d;
            lock_q    <= lock_d;
            prev_hs_q <= prev_hs_d;
            vflag_q   <= vflag_d;
            y_q       <= y_d;
            pst_q     <= pst_d;
            wcnt_q    <= wcnt_d;
            div_q     <= div_d;
            nxt_q     <= nxt_d;
            stb_q     <= stb_d;
            x_q       <= x_d;
            lvl_q     <= lvl_d;
        end
    end
endmodule

// File: tb/tb_vidout_sync_decoder.sv
// tb_vidout_sync_decoder: directed and randomized composite streams checked every cycle
// against a timestamp-based reference model, plus hand-computed literal expectations.
module tb_vidout_sync_decoder;
    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic [10:0] VIN = 11'd500;
    logic        HSYNC_DET, VSYNC_DET, LOCKED, PIX_STB;
    logic [11:0] LINE_LEN;
    logic [8:0]  PIX_X, PIX_Y;
    logic [10:0] PIX_LVL;

    vidout_sync_decoder dut (
        .CLK      (CLK),
        .RES      (RES),
        .VIN      (VIN),
        .HSYNC_DET(HSYNC_DET),
        .VSYNC_DET(VSYNC_DET),
        .LOCKED   (LOCKED),
        .LINE_LEN (LINE_LEN),
        .PIX_STB  (PIX_STB),
        .PIX_X    (PIX_X),
        .PIX_Y    (PIX_Y),
        .PIX_LVL  (PIX_LVL)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: sync runs measured on the registered sample, everything else from
    // timestamps of the last sync and of the line start.
    int t, start, t0l, run, d, m_len, m_y, m_x, m_lvl, m_vq;
    bit m_hs, m_vs, p_hs, p_vs, m_lock, was_lock, prev_hs, vflag, line_on, m_stb;
    initial forever begin
        @(posedge CLK or posedge RES);
        if (RES) begin
            t = 0; start = 0; t0l = 0; run = 0; m_vq = 0;
            m_hs = 0; m_vs = 0; m_lock = 0; prev_hs = 0; vflag = 0; line_on = 0; m_stb = 0;
            m_len = 0; m_y = 0; m_x = 0; m_lvl = 0;
        end else begin
            t++;
            p_hs = m_hs; p_vs = m_vs; was_lock = m_lock;
            m_hs = 0; m_vs = 0;
            if (m_vq < 64) run = (run < 4095) ? run + 1 : 4095;
            else begin
                m_hs = run >= 50 && run < 400;
                m_vs = run >= 400;
                run = 0;
            end
            m_vq = int'(VIN);
            if (p_hs) begin
                d = (t - 1 - start > 4095) ? 4095 : t - 1 - start;
                if (prev_hs) begin
                    m_len = d;
                    m_lock = d >= 1356 && d <= 1372;
                end
                m_y = vflag ? 0 : (m_y < 511 ? m_y + 1 : 511);
                prev_hs = 1; vflag = 0; start = t - 1; line_on = was_lock; t0l = t - 1;
            end else if (p_vs) begin
                prev_hs = 0; vflag = 1; start = t - 1; line_on = 0;
            end else if (t - start >= 1500) begin
                m_lock = 0;
                if (was_lock) line_on = 0;
            end
            d = t - t0l - 200;
            m_stb = line_on && d >= 0 && d % 4 == 0 && d / 4 < 256;
            if (m_stb) begin
                m_x = d / 4;
                m_lvl = m_vq;
            end
        end
    end

    int hs_cnt = 0, vs_cnt = 0, hs_cyc = 0, stb_n = 0, last_line_stb = 0;
    int first_off = -1, first_x = -1, last_stb_cyc = 0, gap_err = 0;
    initial forever begin
        @(negedge CLK);
        chk("hsync", HSYNC_DET, m_hs);
        chk("vsync", VSYNC_DET, m_vs);
        chk("locked", LOCKED, m_lock);
        chk("line_len", LINE_LEN, m_len);
        chk("pix_stb", PIX_STB, m_stb);
        chk("pix_x", PIX_X, m_x);
        chk("pix_y", PIX_Y, m_y);
        chk("pix_lvl", PIX_LVL, m_lvl);
        if (HSYNC_DET) begin
            hs_cnt++; hs_cyc = cyc; last_line_stb = stb_n; stb_n = 0; first_off = -1; first_x = -1;
        end
        if (VSYNC_DET) vs_cnt++;
        if (PIX_STB) begin
            if (stb_n == 0) begin
                first_off = cyc - hs_cyc;
                first_x = int'(PIX_X);
            end else if (cyc - last_stb_cyc != 4) gap_err++;
            last_stb_cyc = cyc;
            stb_n++;
        end
    end

    task automatic drive(input int v);
        @(negedge CLK);
        VIN = 11'(v);
    endtask

    // mode 0: random picture level, 1: ramp 200+(c mod 256), 2: constant 500
    task automatic line(input int s, input int tot, input int mode);
        for (int i = 0; i < tot; i++)
            drive(i < s ? 0 : mode == 1 ? 200 + (cyc % 256) : mode == 2 ? 500 : int'($urandom_range(64, 2047)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish within 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, v0, rise, r;
        repeat (3) @(negedge CLK);
        RES = 0;
        line(0, 100, 2);
        #1;
        chk("reset_locked", LOCKED, 0);
        chk("reset_no_hs", hs_cnt, 0);
        chk("reset_no_vs", vs_cnt, 0);

        h0 = hs_cnt;
        line(49, 200, 2);
        #1; chk("glitch49_ignored", hs_cnt - h0, 0);
        line(50, 50, 2);
        drive(500);
        rise = cyc;
        line(0, 20, 2);
        #1;
        chk("hs50_detected", hs_cnt - h0, 1);
        chk("hs_latency", hs_cyc - rise, 2);

        line(60, 1364, 0);
        line(60, 1364, 0);
        line(60, 1364, 1);
        #1;
        chk("lock_line_len", LINE_LEN, 1364);
        chk("lock_locked", LOCKED, 1);
        chk("model_len", m_len, 1364);
        chk("model_lock", m_lock, 1);
        chk("cap_count", stb_n, 256);
        chk("cap_first_off", first_off, 200);
        chk("cap_first_x", first_x, 0);
        chk("cap_last_x", PIX_X, 255);
        chk("cap_gap", gap_err, 0);

        line(60, 1364, 0);
        line(60, 1380, 0);
        line(60, 1364, 0);
        #1;
        chk("long_line_len", LINE_LEN, 1380);
        chk("long_line_unlock", LOCKED, 0);

        line(60, 1364, 0);
        line(60, 1364, 0);
        #1; chk("relock", LOCKED, 1);
        line(0, 150, 2);
        #1; chk("timeout_not_yet", LOCKED, 1);
        line(0, 100, 2);
        #1; chk("timeout_unlock", LOCKED, 0);

        v0 = vs_cnt;
        repeat (3) line(500, 682, 2);
        #1; chk("vsync_count", vs_cnt - v0, 3);
        line(60, 1364, 0);
        #1; chk("y_after_vsync", PIX_Y, 0);
        line(60, 1364, 0);
        #1;
        chk("y_next_line", PIX_Y, 1);
        chk("vs_relock", LOCKED, 1);

        line(60, 610, 0);
        line(60, 1364, 1);
        #1;
        chk("abort_count", last_line_stb, 103);
        chk("restart_count", stb_n, 256);
        chk("restart_first_off", first_off, 200);
        chk("restart_first_x", first_x, 0);
        chk("restart_gap", gap_err, 0);

        repeat (20) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) line(int'($urandom_range(400, 600)), 700, 0);
            else if (r == 1) line(int'($urandom_range(1, 49)), int'($urandom_range(200, 800)), 0);
            else if (r == 2) line(int'($urandom_range(40, 70)), int'($urandom_range(1000, 1500)), 0);
            else line(int'($urandom_range(50, 70)), 1356 + int'($urandom_range(0, 16)), int'($urandom_range(0, 1)));
        end

        repeat (3) line(60, 1364, 1);
        line(60, 460, 1);
        #1; chk("pre_reset_locked", LOCKED, 1);
        #1 RES = 1;
        #1;
        chk("async_rst_hs", HSYNC_DET, 0);
        chk("async_rst_vs", VSYNC_DET, 0);
        chk("async_rst_locked", LOCKED, 0);
        chk("async_rst_len", LINE_LEN, 0);
        chk("async_rst_stb", PIX_STB, 0);
        chk("async_rst_x", PIX_X, 0);
        chk("async_rst_y", PIX_Y, 0);
        chk("async_rst_lvl", PIX_LVL, 0);
        repeat (2) @(negedge CLK);
        RES = 0;
        h0 = hs_cnt;
        v0 = vs_cnt;
        line(0, 300, 2);
        #1;
        chk("post_rst_no_hs", hs_cnt - h0, 0);
        chk("post_rst_no_vs", vs_cnt - v0, 0);
        chk("post_rst_locked", LOCKED, 0);
        chk("post_rst_len", LINE_LEN, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
